// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the asynchronous FIFO pointer controllers
//   (fifo_wptr_full_ctrl on the write side, rptr_empty on the read side).
//
//   ptr_w()    : pointer width for a given address width (one extra wrap bit)
//   bin2gray() : binary -> reflected Gray code
//   gray2bin() : reflected Gray code -> binary
//
//   The conversion functions work on a fixed-width word. Callers zero-extend
//   their pointer into gray_word_t and size-cast the result back down. The
//   leading zeros do not change the low bits in either direction.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int MAX_PTR_W = 32;

  typedef logic [MAX_PTR_W-1:0] gray_word_t;

  // Pointers carry one bit beyond the address so that full and empty, which
  // share the same address bits, can be told apart.
  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin = '0;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_wptr_full_ctrl_gray_to_bin.sv
// -----------------------------------------------------------------------------
// gray_to_bin
//   Purely combinational Gray-to-binary converter.
//   Bit i of the binary value is the XOR of all Gray bits from the MSB down to
//   bit i. Each bit is written as its own reduction XOR instead of chaining
//   through the previous binary bit, so no signal feeds back into itself.
//
//   Ports:
//     i_gray  in  WIDTH  Gray-coded value
//     o_bin   out WIDTH  binary equivalent
// -----------------------------------------------------------------------------
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[WIDTH-1:i];
  end

endmodule : gray_to_bin

// File: rtl/fifo_wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full_ctrl
//   Write-clock-domain controller of the asynchronous FIFO. It owns the
//   binary and Gray write pointers and drives the memory write port. From
//   the read pointer it derives full, almost-full, fill level and a sticky
//   overflow flag. The read pointer arrives already synchronized into clk.
//
//   Parameters:
//     ADDR_WIDTH   memory address bits (depth = 2**ADDR_WIDTH), must be >= 2
//     AFULL_THRESH almost_full asserts when the fill level >= this (1..depth)
//
//   Ports:
//     clk            in   write-domain clock
//     rst            in   asynchronous active-high reset
//     wr_en          in   write request from the producer
//     rq2_rptr_gray  in   synchronized Gray read pointer (ADDR_WIDTH+1)
//     clr_ovf        in   clears the sticky overflow flag
//     wr_accept      out  wr_en & ~full, memory write enable (combinational)
//     waddr          out  memory write address (ADDR_WIDTH)
//     wptr_gray      out  registered Gray write pointer for the read side
//     full           out  registered full flag
//     almost_full    out  registered, fill level >= AFULL_THRESH
//     wcount         out  registered fill level as seen by the write side
//     overflow       out  sticky, set by a write attempted while full
//
//   The read pointer only reaches registers, so there is no combinational
//   path from rq2_rptr_gray to any output. full and wcount use a read pointer
//   that is at least two cycles old. They can only overstate the occupancy,
//   so a write is never accepted into a slot that is still occupied.
// -----------------------------------------------------------------------------
module fifo_wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH:0]     rq2_rptr_gray,
  input  logic                    clr_ovf,
  output logic                    wr_accept,
  output logic [ADDR_WIDTH-1:0]   waddr,
  output logic [ADDR_WIDTH:0]     wptr_gray,
  output logic                    full,
  output logic                    almost_full,
  output logic [ADDR_WIDTH:0]     wcount,
  output logic                    overflow
);

  localparam int PTR_W = ptr_w(ADDR_WIDTH);

  logic [PTR_W-1:0] r_wbin;
  logic [PTR_W-1:0] r_wptr_gray;
  logic             r_full;
  logic             r_almost_full;
  logic [PTR_W-1:0] r_wcount;
  logic             r_overflow;

  logic             w_wr_accept;
  logic [PTR_W-1:0] w_wbin_next;
  logic [PTR_W-1:0] w_wgray_next;
  logic [PTR_W-1:0] w_rptr_full_ref;
  logic [PTR_W-1:0] w_rbin_sync;
  logic [PTR_W-1:0] w_wcount_next;
  logic             w_full_next;
  logic             w_afull_next;

  // NOTE: all combinational logic is continuous assignments, so every net has
  // exactly one full-coverage driver and no latch can be inferred.
  assign w_wr_accept  = wr_en & ~r_full;
  assign w_wbin_next  = r_wbin + {{(PTR_W-1){1'b0}}, w_wr_accept};
  assign w_wgray_next = PTR_W'(bin2gray(gray_word_t'(w_wbin_next)));

  // The FIFO is full when the write pointer has lapped the read pointer once.
  // In Gray code that means the two top bits are inverted and the rest match.
  assign w_rptr_full_ref = {~rq2_rptr_gray[PTR_W-1:PTR_W-2],
                            rq2_rptr_gray[PTR_W-3:0]};
  assign w_full_next     = (w_wgray_next == w_rptr_full_ref);

  gray_to_bin #(
    .WIDTH (PTR_W)
  ) u_rptr_g2b (
    .i_gray (rq2_rptr_gray),
    .o_bin  (w_rbin_sync)
  );

  // Modulo subtraction handles pointer wrap. The extra pointer bit lets the
  // result span 0..depth inclusive.
  assign w_wcount_next = w_wbin_next - w_rbin_sync;
  assign w_afull_next  = (int'(w_wcount_next) >= AFULL_THRESH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbin        <= '0;
      r_wptr_gray   <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_wcount      <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_wbin        <= w_wbin_next;
      r_wptr_gray   <= w_wgray_next;
      r_full        <= w_full_next;
      r_almost_full <= w_afull_next;
      r_wcount      <= w_wcount_next;
      // Set takes priority: a clear in the same cycle as a rejected write
      // must not hide that rejection.
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign wr_accept   = w_wr_accept;
  assign waddr       = r_wbin[ADDR_WIDTH-1:0];
  assign wptr_gray   = r_wptr_gray;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign wcount      = r_wcount;
  assign overflow    = r_overflow;

endmodule : fifo_wptr_full_ctrl

// File: tb/tb_fifo_wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wptr_full_ctrl
//   Self-checking bench for fifo_wptr_full_ctrl with ADDR_WIDTH=3 and
//   AFULL_THRESH=6. It uses a table of directed vectors (fill, overflow,
//   release and wrap), hand-written reset sequences, and a randomized run
//   against a counting model of writes and reads.
// -----------------------------------------------------------------------------
module tb_fifo_wptr_full_ctrl;

  localparam int AW    = 3;
  localparam int TH    = 6;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          clr_ovf;
  logic [PW-1:0] rq2_rptr_gray;
  logic          wr_accept;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr_gray;
  logic          full;
  logic          almost_full;
  logic [PW-1:0] wcount;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  fifo_wptr_full_ctrl #(
    .ADDR_WIDTH   (AW),
    .AFULL_THRESH (TH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .rq2_rptr_gray (rq2_rptr_gray),
    .clr_ovf       (clr_ovf),
    .wr_accept     (wr_accept),
    .waddr         (waddr),
    .wptr_gray     (wptr_gray),
    .full          (full),
    .almost_full   (almost_full),
    .wcount        (wcount),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gray code of a read/write count, from the definition n ^ (n >> 1).
  function automatic logic [PW-1:0] gray_of(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  // Directed vector: inputs for one cycle, expected comb outputs before the
  // edge (acc, waddr) and expected registered outputs after it.
  typedef struct {
    logic          wr;
    int            rd;
    logic          clr;
    logic          acc;
    logic [AW-1:0] waddr;
    logic [PW-1:0] gray;
    logic          full;
    logic          afull;
    logic [PW-1:0] wcount;
    logic          ovf;
  } vec_t;

  vec_t tbl[$];

  // Pulse rst between edges, then release it on a falling edge.
  task automatic do_reset();
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    rq2_rptr_gray = '0;
    #2 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Random-phase model state
  int   m_wr, rd_true, rd_d1, rd_d2, occ_seen;
  logic m_full, m_ovf, exp_acc, wrapped;
  logic [PW-1:0] prev_gray;

  initial begin
    rst = 1'b0; wr_en = 1'b0; clr_ovf = 1'b0; rq2_rptr_gray = '0;

    // ---------------- reset asserted between edges ----------------
    #2 rst = 1'b1; wr_en = 1'b1;
    #1;
    check("rst_wptr_gray", 32'(wptr_gray), 32'h0);
    check("rst_waddr",     32'(waddr),     32'h0);
    check("rst_full",      32'(full),      32'h0);
    check("rst_afull",     32'(almost_full), 32'h0);
    check("rst_wcount",    32'(wcount),    32'h0);
    check("rst_overflow",  32'(overflow),  32'h0);
    check("rst_accept_follows_wr_en", 32'(wr_accept), 32'h1);
    wr_en = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // ---------------- directed table ----------------
    // fill 8 slots with read pointer 0
    tbl.push_back('{1'b1, 0, 1'b0, 1'b1, 3'd0, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0});
    tbl.push_back('{1'b1, 0, 1'b0, 1'b1, 3'd1, 4'b0011, 1'b0, 1'b0, 4'd2, 1'b0});
    tbl.push_back('{1'b1, 0, 1'b0, 1'b1, 3'd2, 4'b0010, 1'b0, 1'b0, 4'd3, 1'b0});
    tbl.push_back('{1'b1, 0, 1'b0, 1'b1, 3'd3, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b0});
    tbl.push_back('{1'b1, 0, 1'b0, 1'b1, 3'd4, 4'b0111, 1'b0, 1'b0, 4'd5, 1'b0});
    tbl.push_back('{1'b1, 0, 1'b0, 1'b1, 3'd5, 4'b0101, 1'b0, 1'b1, 4'd6, 1'b0});
    tbl.push_back('{1'b1, 0, 1'b0, 1'b1, 3'd6, 4'b0100, 1'b0, 1'b1, 4'd7, 1'b0});
    tbl.push_back('{1'b1, 0, 1'b0, 1'b1, 3'd7, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0});
    // blocked write sets overflow, pointer holds
    tbl.push_back('{1'b1, 0, 1'b0, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1});
    // clear with no write
    tbl.push_back('{1'b0, 0, 1'b1, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0});
    // clear together with a blocked write: set wins
    tbl.push_back('{1'b1, 0, 1'b1, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1});
    tbl.push_back('{1'b0, 0, 1'b1, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0});
    // read pointer advances to 1: full releases
    tbl.push_back('{1'b0, 1, 1'b0, 1'b0, 3'd0, 4'b1100, 1'b0, 1'b1, 4'd7, 1'b0});
    // one more write at wrapped address 0 fills again
    tbl.push_back('{1'b1, 1, 1'b0, 1'b1, 3'd0, 4'b1101, 1'b1, 1'b1, 4'd8, 1'b0});

    foreach (tbl[i]) begin
      wr_en         = tbl[i].wr;
      clr_ovf       = tbl[i].clr;
      rq2_rptr_gray = gray_of(tbl[i].rd);
      #1;
      check($sformatf("vec%0d_accept", i), 32'(wr_accept), 32'(tbl[i].acc));
      check($sformatf("vec%0d_waddr",  i), 32'(waddr),     32'(tbl[i].waddr));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_gray",   i), 32'(wptr_gray),   32'(tbl[i].gray));
      check($sformatf("vec%0d_full",   i), 32'(full),        32'(tbl[i].full));
      check($sformatf("vec%0d_afull",  i), 32'(almost_full), 32'(tbl[i].afull));
      check($sformatf("vec%0d_wcount", i), 32'(wcount),      32'(tbl[i].wcount));
      check($sformatf("vec%0d_ovf",    i), 32'(overflow),    32'(tbl[i].ovf));
    end

    // ---------------- async reset mid-fill ----------------
    do_reset();
    wr_en = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    check("midrst_pre_wcount", 32'(wcount), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("midrst_wcount", 32'(wcount),      32'h0);
    check("midrst_gray",   32'(wptr_gray),   32'h0);
    check("midrst_afull",  32'(almost_full), 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    wr_en = 1'b1;
    #1;
    check("midrst_restart_waddr",  32'(waddr),     32'h0);
    check("midrst_restart_accept", 32'(wr_accept), 32'h1);
    @(posedge clk);
    #1;
    check("midrst_restart_gray", 32'(wptr_gray), 32'b0001);
    wr_en = 1'b0;

    // ---------------- randomized wrap stress ----------------
    do_reset();
    m_wr = 0; rd_true = 0; rd_d1 = 0; rd_d2 = 0;
    m_full = 1'b0; m_ovf = 1'b0; wrapped = 1'b0;
    for (int cyc = 0; cyc < 3000 && m_wr < 56; cyc++) begin
      wr_en         = ($urandom_range(3) != 0);
      clr_ovf       = ($urandom_range(7) == 0);
      rq2_rptr_gray = gray_of(rd_d2);
      #1;
      exp_acc = wr_en & ~m_full;
      check("rnd_accept", 32'(wr_accept), 32'(exp_acc));
      check("rnd_waddr",  32'(waddr),     32'(m_wr % DEPTH));
      if (wr_accept === 1'b1)
        check("rnd_no_write_into_true_full", 32'((m_wr - rd_true) < DEPTH), 32'h1);
      prev_gray = wptr_gray;
      @(posedge clk);
      if (wr_en && m_full) m_ovf = 1'b1;
      else if (clr_ovf)    m_ovf = 1'b0;
      if (exp_acc) m_wr++;
      occ_seen = m_wr - rd_d2;
      m_full   = (occ_seen == DEPTH);
      // read side: the pointer it shows here appears two cycles later
      rd_d2 = rd_d1;
      rd_d1 = rd_true;
      if (rd_true < m_wr && $urandom_range(1) == 1) rd_true++;
      #1;
      check("rnd_gray",   32'(wptr_gray),   32'(gray_of(m_wr)));
      check("rnd_full",   32'(full),        32'(m_full));
      check("rnd_afull",  32'(almost_full), 32'(occ_seen >= TH));
      check("rnd_wcount", 32'(wcount),      32'(occ_seen));
      check("rnd_ovf",    32'(overflow),    32'(m_ovf));
      check("rnd_wcount_ge_true_occ", 32'(int'(wcount) >= (m_wr - rd_true)), 32'h1);
      if (prev_gray == 4'b1000 && wptr_gray == 4'b0000) wrapped = 1'b1;
    end
    check("rnd_enough_writes",  32'(m_wr >= 56), 32'h1);
    check("rnd_gray_wrap_seen", 32'(wrapped),    32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fifo_wptr_full_ctrl
